// File: rtl/mii_tx_sched_if.sv
// Bundle of source-side and transmitter-side signals around the MII TX scheduler.
// master = the scheduler, slave = frame builders plus MII nibble transmitter.
interface mii_tx_sched_if;
  logic       s0_req;
  logic [7:0] s0_data;
  logic       s0_valid;
  logic       s0_last;
  logic       s0_ready;
  logic       s0_grant;
  logic       s1_req;
  logic [7:0] s1_data;
  logic       s1_valid;
  logic       s1_last;
  logic       s1_ready;
  logic       s1_grant;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       underrun_err;
  logic       oversize_err;

  modport master (
    input  s0_req, s0_data, s0_valid, s0_last,
    input  s1_req, s1_data, s1_valid, s1_last,
    input  tx_ready,
    output s0_ready, s0_grant, s1_ready, s1_grant,
    output tx_start, tx_data, tx_valid, busy, underrun_err, oversize_err
  );

  modport slave (
    output s0_req, s0_data, s0_valid, s0_last,
    output s1_req, s1_data, s1_valid, s1_last,
    output tx_ready,
    input  s0_ready, s0_grant, s1_ready, s1_grant,
    input  tx_start, tx_data, tx_valid, busy, underrun_err, oversize_err
  );
endinterface

// File: rtl/mii_tx_sched.sv
// Round-robin scheduler for the shared MII byte transmitter: grants one of two
// frame sources, prepends preamble/SFD, passes payload through, enforces the IFG.
module mii_tx_sched #(
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_CYCLES   = 24,
  parameter int MAX_FRAME    = 1518,
  parameter int CNT_W        = 11
) (
  input logic            clk,
  input logic            reset,
  mii_tx_sched_if.master bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_PRE     = 3'd2;
  localparam logic [2:0] S_SFD     = 3'd3;
  localparam logic [2:0] S_PAYLOAD = 3'd4;
  localparam logic [2:0] S_IFG     = 3'd5;

  logic [2:0]       state_q, state_d;
  logic             sel_q, sel_d;
  logic             last_q, last_d;
  logic             g0_q, g0_d;
  logic             g1_q, g1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             src_valid;
  logic             src_last;
  logic [7:0]       src_data;
  logic             start_c;
  logic [7:0]       data_c;
  logic             valid_c;
  logic             rdy0_c;
  logic             rdy1_c;
  logic             under_c;
  logic             over_c;

  assign src_valid = sel_q ? bus.s1_valid : bus.s0_valid;
  assign src_last  = sel_q ? bus.s1_last  : bus.s0_last;
  assign src_data  = sel_q ? bus.s1_data  : bus.s0_data;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    g0_d    = g0_q;
    g1_d    = g1_q;
    cnt_d   = cnt_q;
    start_c = 1'b0;
    data_c  = '0;
    valid_c = 1'b0;
    rdy0_c  = 1'b0;
    rdy1_c  = 1'b0;
    under_c = 1'b0;
    over_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // last_q names the previous winner; on a tie the other source wins
        if (bus.s0_req || bus.s1_req) begin
          sel_d   = (bus.s0_req && bus.s1_req) ? ~last_q : bus.s1_req;
          last_d  = sel_d;
          g0_d    = ~sel_d;
          g1_d    = sel_d;
          state_d = S_START;
        end
      end
      S_START: begin
        start_c = 1'b1;
        cnt_d   = '0;
        state_d = S_PRE;
      end
      S_PRE: begin
        data_c  = 8'h55;
        valid_c = 1'b1;
        if (bus.tx_ready) begin
          if (cnt_q == CNT_W'(PREAMBLE_LEN - 1)) begin
            cnt_d   = '0;
            state_d = S_SFD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_SFD: begin
        data_c  = 8'hD5;
        valid_c = 1'b1;
        if (bus.tx_ready) begin
          cnt_d   = '0;
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        data_c  = src_data;
        valid_c = src_valid;
        rdy0_c  = ~sel_q & bus.tx_ready & src_valid;
        rdy1_c  = sel_q & bus.tx_ready & src_valid;
        // starvation, final byte and length limit all close the frame the same way
        if (!src_valid || (bus.tx_ready && (src_last || cnt_q == CNT_W'(MAX_FRAME - 1)))) begin
          under_c = ~src_valid;
          over_c  = src_valid & ~src_last;
          g0_d    = 1'b0;
          g1_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_IFG;
        end else if (bus.tx_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_IFG: begin
        if (cnt_q == CNT_W'(IFG_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        g0_d    = 1'b0;
        g1_d    = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      g0_q    <= 1'b0;
      g1_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      g0_q    <= g0_d;
      g1_q    <= g1_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.tx_start     = start_c;
  assign bus.tx_data      = data_c;
  assign bus.tx_valid     = valid_c;
  assign bus.s0_ready     = rdy0_c;
  assign bus.s1_ready     = rdy1_c;
  assign bus.s0_grant     = g0_q;
  assign bus.s1_grant     = g1_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.underrun_err = under_c;
  assign bus.oversize_err = over_c;

endmodule

// File: tb/tb_mii_tx_sched.sv
// Bench for mii_tx_sched: directed scenarios plus randomized frames, checked
// against a frame-level model of the expected byte stream, arbitration and gaps.
module tb_mii_tx_sched;
  localparam int PRE  = 7;
  localparam int IFG  = 24;
  localparam int MAXF = 1518;

  logic clk = 1'b0;
  logic reset;
  always #20 clk = ~clk;

  mii_tx_sched_if bus();

  mii_tx_sched #(.PREAMBLE_LEN(PRE), .IFG_CYCLES(IFG), .MAX_FRAME(MAXF), .CNT_W(11))
    dut (.clk(clk), .reset(reset), .bus(bus));

  // source-side frame storage, written only by the stimulus process
  logic [7:0] fdata [0:1][0:2047];
  int  flen [2];
  int  fstarve [2];
  int  fidx [2];
  bit  fnolast [2];
  bit  fpend [2];
  bit  fact [2];
  bit  fwasg [2];
  int  rdy_mode;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  // model state and logs, written only by the compare process
  logic [7:0] exp_q [$];
  logic [7:0] seen_q [$];
  int  src_log [$];
  int  exp_src, model_last = 1, end_cyc;
  bit  in_frame;
  int  exp_under, exp_over, got_under, got_over;
  int  busy_cnt = 0, under_cnt = 0, over_cnt = 0, frames_done = 0, start_cnt = 0;
  bit  pr0, pr1, prev_stall, prev_start;
  logic [7:0] prev_data;

  always @(negedge clk) begin
    int n;
    logic [7:0] e;
    if (reset) begin
      exp_q.delete();
      in_frame   = 1'b0;
      model_last = 1;
      pr0 = 1'b0; pr1 = 1'b0; prev_stall = 1'b0; prev_start = 1'b0;
    end else begin
      cyc++;
      chk("grant_excl", int'(bus.s0_grant & bus.s1_grant), 0);
      chk("ready_needs_grant", int'((bus.s0_ready & ~bus.s0_grant) | (bus.s1_ready & ~bus.s1_grant)), 0);
      if (bus.busy) busy_cnt++;
      if (bus.tx_start) begin
        start_cnt++;
        chk("start_once", int'(prev_start), 0);
        chk("start_no_valid", int'(bus.tx_valid), 0);
        // arbitration decided from the requests seen on the preceding IDLE cycle
        exp_src = (pr0 && pr1) ? (model_last == 0 ? 1 : 0) : (pr1 ? 1 : 0);
        model_last = exp_src;
        src_log.push_back(bus.s1_grant ? 1 : 0);
        n = (fstarve[exp_src] >= 0) ? fstarve[exp_src] : (fnolast[exp_src] ? MAXF : flen[exp_src]);
        exp_q.delete();
        for (int i = 0; i < PRE; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < n; i++) exp_q.push_back(fdata[exp_src][i]);
        exp_under = (fstarve[exp_src] >= 0) ? 1 : 0;
        exp_over  = (!exp_under && fnolast[exp_src]) ? 1 : 0;
        got_under = 0; got_over = 0;
        in_frame = 1'b1; end_cyc = -1;
      end
      if (in_frame && end_cyc < 0)
        chk("grant_src", int'({bus.s1_grant, bus.s0_grant}), exp_src == 1 ? 2 : 1);
      if (bus.tx_valid && bus.tx_ready) begin
        seen_q.push_back(bus.tx_data);
        chk("extra_byte", int'(exp_q.size() == 0), 0);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("tx_data", int'(bus.tx_data), int'(e));
          if (exp_q.size() == 0 && !exp_under && in_frame) end_cyc = cyc;
        end
      end
      if (bus.underrun_err) begin
        under_cnt++; got_under++;
        chk("underrun_at", exp_q.size(), 0);
        if (in_frame) end_cyc = cyc;
      end
      if (bus.oversize_err) begin
        over_cnt++; got_over++;
        chk("oversize_at", exp_q.size(), 0);
      end
      if (in_frame && end_cyc >= 0 && cyc > end_cyc) begin
        if (bus.busy) begin
          chk("ifg_quiet", int'({bus.tx_valid, bus.s1_grant, bus.s0_grant}), 0);
          if (cyc - end_cyc > IFG + 1) begin
            chk("ifg_len", cyc - end_cyc, IFG + 1);
            in_frame = 1'b0; frames_done++;
          end
        end else begin
          chk("ifg_len", cyc - end_cyc, IFG + 1);
          chk("underrun_cnt", got_under, exp_under);
          chk("oversize_cnt", got_over, exp_over);
          in_frame = 1'b0; frames_done++;
        end
      end
      if (prev_stall && bus.tx_valid) chk("stall_hold", int'(bus.tx_data), int'(prev_data));
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_data  = bus.tx_data;
      prev_start = bus.tx_start;
      pr0 = bus.s0_req;
      pr1 = bus.s1_req;
    end
  end

  task automatic drive();
    bus.s0_req   = fpend[0];
    bus.s0_valid = fact[0] && !fpend[0] && bus.s0_grant && (fidx[0] < flen[0]) && (fidx[0] != fstarve[0]);
    bus.s0_data  = fdata[0][fidx[0]];
    bus.s0_last  = (fidx[0] == flen[0] - 1) && !fnolast[0];
    bus.s1_req   = fpend[1];
    bus.s1_valid = fact[1] && !fpend[1] && bus.s1_grant && (fidx[1] < flen[1]) && (fidx[1] != fstarve[1]);
    bus.s1_data  = fdata[1][fidx[1]];
    bus.s1_last  = (fidx[1] == flen[1] - 1) && !fnolast[1];
  endtask

  task automatic advance(input int s, input bit hs, input bit g);
    if (hs) fidx[s]++;
    if (fpend[s] && g) fpend[s] = 1'b0;
    else if (fact[s] && !fpend[s] && fwasg[s] && !g) fact[s] = 1'b0;
    fwasg[s] = g;
  endtask

  task automatic tick();
    bit hs0, hs1;
    @(negedge clk);
    hs0 = bus.s0_valid && bus.s0_ready;
    hs1 = bus.s1_valid && bus.s1_ready;
    @(posedge clk);
    #1;
    advance(0, hs0, bus.s0_grant);
    advance(1, hs1, bus.s1_grant);
    case (rdy_mode)
      0:       bus.tx_ready = 1'b1;
      1:       bus.tx_ready = ($urandom_range(0, 3) != 0);
      default: bus.tx_ready = !bus.tx_ready;
    endcase
    drive();
  endtask

  task automatic load(input int s, input int len, input int starve, input bit nolast);
    for (int i = 0; i < 2048; i++) fdata[s][i] = 8'($urandom);
    flen[s] = len; fstarve[s] = starve; fnolast[s] = nolast;
    fidx[s] = 0; fpend[s] = 1'b1; fact[s] = 1'b1; fwasg[s] = 1'b0;
    drive();
  endtask

  task automatic wait_frames(input int n, input int budget);
    int target, c, base;
    base = frames_done;
    target = frames_done + n;
    c = 0;
    while (frames_done < target && c < budget) begin
      tick();
      c++;
    end
    chk("frames_completed", frames_done - base, n);
  endtask

  task automatic zero_check(input string nm);
    @(negedge clk);
    chk(nm, int'({bus.tx_start, bus.tx_valid, bus.tx_data, bus.s0_ready, bus.s0_grant,
                  bus.s1_ready, bus.s1_grant, bus.busy, bus.underrun_err, bus.oversize_err}), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fact[0] = 1'b0; fact[1] = 1'b0; fpend[0] = 1'b0; fpend[1] = 1'b0;
    drive();
    tick();
    zero_check("reset_outputs");
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive();
  endtask

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    logic [7:0] lit [11];
    int base, base2, n55, loaded, c, rl, st;
    lit = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5, 8'hAA, 8'hBB, 8'hCC};
    for (int s = 0; s < 2; s++) begin
      flen[s] = 0; fstarve[s] = -1; fidx[s] = 0; fnolast[s] = 1'b0;
      fpend[s] = 1'b0; fact[s] = 1'b0; fwasg[s] = 1'b0;
    end
    rdy_mode = 0;
    bus.tx_ready = 1'b0;
    reset = 1'b1;
    drive();
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // three-byte frame from s0 with tx_ready held high
    rdy_mode = 0;
    base = seen_q.size();
    base2 = busy_cnt;
    c = start_cnt;
    load(0, 3, -1, 1'b0);
    fdata[0][0] = 8'hAA; fdata[0][1] = 8'hBB; fdata[0][2] = 8'hCC;
    drive();
    wait_frames(1, 200);
    chk("t1_len", seen_q.size() - base, 11);
    for (int i = 0; i < 11; i++)
      if (base + i < seen_q.size()) chk("t1_byte", int'(seen_q[base + i]), int'(lit[i]));
    chk("t1_busy_cycles", busy_cnt - base2, 36);
    chk("t1_start_pulses", start_cnt - c, 1);

    // simultaneous requests right after reset: s0 first, then s1
    do_reset();
    base = src_log.size();
    load(0, 4, -1, 1'b0);
    load(1, 3, -1, 1'b0);
    wait_frames(2, 400);
    chk("t2_frames", src_log.size() - base, 2);
    if (src_log.size() >= base + 2) begin
      chk("t2_first", src_log[base], 0);
      chk("t2_second", src_log[base + 1], 1);
    end

    // tx_ready toggling every cycle
    rdy_mode = 2;
    base = seen_q.size();
    load(0, 2, -1, 1'b0);
    wait_frames(1, 300);
    n55 = 0;
    for (int i = base; i < seen_q.size() && seen_q[i] == 8'h55 && n55 < 20; i++) n55++;
    chk("t3_preamble_bytes", n55, 7);
    if (seen_q.size() > base + 7) chk("t3_sfd", int'(seen_q[base + 7]), 8'hD5);

    // s1 starves after two payload bytes
    rdy_mode = 0;
    c = under_cnt;
    load(1, 6, 2, 1'b0);
    wait_frames(1, 300);
    chk("t4_underrun_pulses", under_cnt - c, 1);

    // s0 streams without ever marking last
    c = over_cnt;
    base = seen_q.size();
    load(0, 1600, -1, 1'b1);
    wait_frames(1, 2000);
    chk("t5_oversize_pulses", over_cnt - c, 1);
    chk("t5_payload_bytes", seen_q.size() - base - 8, MAXF);

    // reset in the middle of a payload, then a tie must go to s0
    base = seen_q.size();
    load(0, 20, -1, 1'b0);
    c = 0;
    while (seen_q.size() < base + 13 && c < 100) begin
      tick();
      c++;
    end
    chk("t6_bytes_before_reset", seen_q.size() - base, 13);
    do_reset();
    base = src_log.size();
    load(0, 5, -1, 1'b0);
    load(1, 5, -1, 1'b0);
    wait_frames(1, 300);
    if (src_log.size() > base) chk("t6_tie_after_reset", src_log[base], 0);

    // randomized frames from both sources
    rdy_mode = 1;
    for (int it = 0; it < 30; it++) begin
      loaded = 0;
      for (int s = 0; s < 2; s++) begin
        if (!fact[s] && $urandom_range(0, 1) == 1) begin
          rl = $urandom_range(1, 24);
          st = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, rl - 1)) : -1;
          load(s, rl, st, 1'b0);
          loaded++;
        end
      end
      if (loaded == 0) begin
        for (int s = 0; s < 2; s++) begin
          if (loaded == 0 && !fact[s]) begin
            load(s, $urandom_range(1, 24), -1, 1'b0);
            loaded++;
          end
        end
      end
      wait_frames(1, 3000);
    end
    c = 0;
    while ((fact[0] || fact[1] || bus.busy) && c < 5000) begin
      tick();
      c++;
    end
    chk("drain_idle", int'(fact[0] || fact[1] || bus.busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
